matrix_store_writer: RTL and testbench
======================================

# matrix_store_writer

Initiator-side client of the matrix directory's allocation/commit interface. It accepts a matrix's dimensions and a row-major element stream from the input/generator path. It then:
- requests a slot and start address from the manager,
- writes every element into the matrix data BRAM,
- commits the slot's metadata only after the last element is written.

It sits between the UART/input parser (or compute result path) and both the matrix manager and the data BRAM.

## Interface
Parameters:
- ELEMENT_WIDTH, 8, element data width
- ADDR_WIDTH, 12, BRAM address width; matches manager address width
- MAX_DIM, 5, largest legal row/column count
- ALLOC_WAIT, 2, cycles to wait for alloc_valid after alloc_req
- TIMEOUT_CYCLES, 1023, stream inactivity limit (only with STORE_WRITE_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a store; sampled only while busy=0
- req_m, req_n  in  5 each  requested rows/columns
- abort  in  1  cancel the store in progress
- busy  out  1  high whenever state is not IDLE
- in_valid  in  1  element beat valid
- in_data  in  ELEMENT_WIDTH  element, row-major
- in_ready  out  1  high only in WRITE
- alloc_req  out  1  one-cycle allocation request
- alloc_m, alloc_n  out  5 each  dims held from start
- alloc_slot  in  4  granted slot
- alloc_addr  in  ADDR_WIDTH  granted start address
- alloc_valid  in  1  grant strobe
- bram_we  out  1  BRAM write enable
- bram_addr  out  ADDR_WIDTH  BRAM write address
- bram_din  out  ELEMENT_WIDTH  BRAM write data
- commit_req  out  1  one-cycle commit strobe
- commit_slot  out  4  slot being committed
- commit_m, commit_n  out  5 each  committed dimensions
- commit_addr  out  ADDR_WIDTH  committed start address
- done  out  1  one-cycle success pulse
- result_slot  out  4  committed slot; held until next done
- err  out  1  one-cycle failure pulse
- err_code  out  2  reason code, qualified by err: 0 DIM, 1 NOSPACE, 2 ABORT, 3 TIMEOUT

## Operation
- States: IDLE, ALLOC, WAIT_ALLOC, WRITE, COMMIT.
- IDLE, start=1:
  - If req_m or req_n is 0 or greater than MAX_DIM: err with code 0, stay in IDLE, no alloc_req.
  - Otherwise latch dims, compute total = m*n (10 bits), go to ALLOC.
- ALLOC: alloc_req=1 for exactly one cycle, then go to WAIT_ALLOC.
- WAIT_ALLOC:
  - alloc_valid=1 within ALLOC_WAIT cycles: latch slot and addr, clear index, go to WRITE.
  - No alloc_valid within ALLOC_WAIT cycles: err with code 1, go to IDLE.
- WRITE:
  - Each in_valid&&in_ready beat writes bram_addr = base + idx (mod 2^ADDR_WIDTH), then idx++.
  - The beat with idx == total-1 moves to COMMIT.
- COMMIT:
  - commit_req=1 for one cycle with the latched slot, dims and base.
  - The next cycle: done=1, result_slot=slot, return to IDLE.
- Slot reuse: a granted slot may already hold a valid matrix (FIFO overwrite). Its old data is overwritten before the commit; no special handling.
- abort in ALLOC, WAIT_ALLOC or WRITE:
  - Next cycle: IDLE, err with code 2, no commit.
  - Elements already written stay in BRAM, unreferenced.
- abort on the same cycle as the final beat: abort wins and that beat is not written.
- abort on the same cycle as alloc_valid: abort wins.
- abort in IDLE or COMMIT is ignored; a commit in progress always completes.

## Timing
- Reset values:
  - state IDLE.
  - All strobes 0: alloc_req, bram_we, commit_req, done, err.
  - busy=0, in_ready=0.
  - All data/address outputs 0, result_slot 4'hF.
- All outputs are registered except in_ready, which is decoded from state.
- Start latency: start accepted at cycle T gives alloc_req=1 at T+1. The manager grant normally arrives at T+2, and WRITE begins at T+3.
- Write latency: a beat accepted at cycle k gives bram_we/addr/din at k+1.
- Completion: last beat accepted at L gives final bram_we and commit_req at L+1, done at L+2, busy=0 at L+2.
- Minimum store time: 25 elements at full rate take 3 + 25 + 2 cycles.
- Reset mid-operation: immediate return to IDLE; no commit is ever issued for a partial matrix.

## Configuration
- STORE_WRITE_TIMEOUT_EN defined:
  - A counter runs in WRITE and clears on each accepted beat.
  - At TIMEOUT_CYCLES with no beat: IDLE, err with code 3, no commit.
- STORE_WRITE_TIMEOUT_EN undefined:
  - No counter is built; WRITE waits indefinitely.
  - err_code 3 is never produced.

## Test plan
- 2x3 store, grant slot 4 addr 0x010, six back-to-back beats 1..6 -> BRAM writes 0x010..0x015 with data 1..6; commit_req with slot 4, m=2, n=3, addr 0x010; done at L+2, result_slot=4.
- start with m=0 and with n=6 -> err code 0 in the next cycle, alloc_req never asserted, busy stays 0.
- alloc_valid withheld -> err code 1 after ALLOC_WAIT cycles, no bram_we.
- 3x3 store, in_valid gapped (every other cycle), abort asserted after 4 beats -> 4 BRAM writes, err code 2, no commit_req.
- abort coincident with final beat of 1x1 store -> zero BRAM writes, err code 2; start held high during busy is ignored.
- (STORE_WRITE_TIMEOUT_EN, TIMEOUT_CYCLES=8) stream stalls after 2 beats -> err code 3 after 8 idle cycles, no commit.

Source files
------------

// File: rtl/matrix_store_writer.sv
// Streams one row-major matrix into the data BRAM: allocate a slot, write every element, then commit.
// Optional stream-inactivity timeout is built only when STORE_WRITE_TIMEOUT_EN is defined.
module matrix_store_writer #(
  parameter int ELEMENT_WIDTH  = 8,
  parameter int ADDR_WIDTH     = 12,
  parameter int MAX_DIM        = 5,
  parameter int ALLOC_WAIT     = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [4:0]               req_m,
  input  logic [4:0]               req_n,
  input  logic                     abort,
  output logic                     busy,
  input  logic                     in_valid,
  input  logic [ELEMENT_WIDTH-1:0] in_data,
  output logic                     in_ready,
  output logic                     alloc_req,
  output logic [4:0]               alloc_m,
  output logic [4:0]               alloc_n,
  input  logic [3:0]               alloc_slot,
  input  logic [ADDR_WIDTH-1:0]    alloc_addr,
  input  logic                     alloc_valid,
  output logic                     bram_we,
  output logic [ADDR_WIDTH-1:0]    bram_addr,
  output logic [ELEMENT_WIDTH-1:0] bram_din,
  output logic                     commit_req,
  output logic [3:0]               commit_slot,
  output logic [4:0]               commit_m,
  output logic [4:0]               commit_n,
  output logic [ADDR_WIDTH-1:0]    commit_addr,
  output logic                     done,
  output logic [3:0]               result_slot,
  output logic                     err,
  output logic [1:0]               err_code
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_ALLOC      = 3'd1;
  localparam logic [2:0] S_WAIT_ALLOC = 3'd2;
  localparam logic [2:0] S_WRITE      = 3'd3;
  localparam logic [2:0] S_COMMIT     = 3'd4;

  localparam logic [1:0] ERR_DIM     = 2'd0;
  localparam logic [1:0] ERR_NOSPACE = 2'd1;
  localparam logic [1:0] ERR_ABORT   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [4:0] MAX_DIM_V = 5'(MAX_DIM);
  localparam int WAIT_W = (ALLOC_WAIT > 1) ? $clog2(ALLOC_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ALLOC_WAIT - 1);

  logic [2:0]               state;
  logic [4:0]               m_q;
  logic [4:0]               n_q;
  logic [9:0]               total_q;
  logic [9:0]               idx_q;
  logic [3:0]               slot_q;
  logic [ADDR_WIDTH-1:0]    base_q;
  logic [WAIT_W-1:0]        wait_cnt;

  logic beat;
  logic last_beat;
  logic dim_bad;
  logic timeout_hit;

  assign in_ready  = (state == S_WRITE);
  assign beat      = in_valid && in_ready && !abort;
  assign last_beat = beat && (idx_q == total_q - 10'd1);
  assign dim_bad   = (req_m == 5'd0) || (req_n == 5'd0) ||
                     (req_m > MAX_DIM_V) || (req_n > MAX_DIM_V);

  // The latched request doubles as both the allocation and the commit descriptor.
  assign alloc_m     = m_q;
  assign alloc_n     = n_q;
  assign commit_m    = m_q;
  assign commit_n    = n_q;
  assign commit_slot = slot_q;
  assign commit_addr = base_q;

`ifdef STORE_WRITE_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] idle_cnt;

  assign timeout_hit = (state == S_WRITE) && !beat && (idle_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if ((state != S_WRITE) || beat) begin
      idle_cnt <= '0;
    end else if (!timeout_hit) begin
      idle_cnt <= idle_cnt + TO_W'(1);
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit        = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      alloc_req   <= 1'b0;
      bram_we     <= 1'b0;
      bram_addr   <= '0;
      bram_din    <= '0;
      commit_req  <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_code    <= ERR_DIM;
      result_slot <= 4'hF;
      m_q         <= '0;
      n_q         <= '0;
      total_q     <= '0;
      idx_q       <= '0;
      slot_q      <= '0;
      base_q      <= '0;
      wait_cnt    <= '0;
    end else begin
      // NOTE: strobes default low here so each one is a single-cycle pulse
      // unless the state below re-asserts it.
      alloc_req  <= 1'b0;
      bram_we    <= 1'b0;
      commit_req <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            if (dim_bad) begin
              err      <= 1'b1;
              err_code <= ERR_DIM;
            end else begin
              m_q       <= req_m;
              n_q       <= req_n;
              total_q   <= {5'd0, req_m} * {5'd0, req_n};
              alloc_req <= 1'b1;
              busy      <= 1'b1;
              state     <= S_ALLOC;
            end
          end
        end

        S_ALLOC: begin
          if (abort) begin
            err      <= 1'b1;
            err_code <= ERR_ABORT;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else begin
            wait_cnt <= '0;
            state    <= S_WAIT_ALLOC;
          end
        end

        S_WAIT_ALLOC: begin
          // Abort outranks a grant arriving in the same cycle.
          if (abort) begin
            err      <= 1'b1;
            err_code <= ERR_ABORT;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else if (alloc_valid) begin
            slot_q <= alloc_slot;
            base_q <= alloc_addr;
            idx_q  <= '0;
            state  <= S_WRITE;
          end else if (wait_cnt == WAIT_LAST) begin
            err      <= 1'b1;
            err_code <= ERR_NOSPACE;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        S_WRITE: begin
          if (abort) begin
            err      <= 1'b1;
            err_code <= ERR_ABORT;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else if (beat) begin
            bram_we   <= 1'b1;
            bram_addr <= base_q + ADDR_WIDTH'(idx_q);
            bram_din  <= in_data;
            idx_q     <= idx_q + 10'd1;
            if (last_beat) begin
              commit_req <= 1'b1;
              state      <= S_COMMIT;
            end
          end else if (timeout_hit) begin
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
        end

        S_COMMIT: begin
          done        <= 1'b1;
          result_slot <= slot_q;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_store_writer.sv
// Self-checking bench for matrix_store_writer: directed steps plus randomized stores
// compared against a transaction-level model of the expected BRAM writes and commit.
`timescale 1ns/1ps
module tb_matrix_store_writer;

  localparam int EW    = 8;
  localparam int AW    = 12;
  localparam int AWAIT = 2;
`ifdef STORE_WRITE_TIMEOUT_EN
  localparam int TOC = 8;
`else
  localparam int TOC = 1023;
`endif

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [4:0]    req_m;
  logic [4:0]    req_n;
  logic          abort;
  logic          busy;
  logic          in_valid;
  logic [EW-1:0] in_data;
  logic          in_ready;
  logic          alloc_req;
  logic [4:0]    alloc_m;
  logic [4:0]    alloc_n;
  logic [3:0]    alloc_slot;
  logic [AW-1:0] alloc_addr;
  logic          alloc_valid;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [EW-1:0] bram_din;
  logic          commit_req;
  logic [3:0]    commit_slot;
  logic [4:0]    commit_m;
  logic [4:0]    commit_n;
  logic [AW-1:0] commit_addr;
  logic          done;
  logic [3:0]    result_slot;
  logic          err;
  logic [1:0]    err_code;

  matrix_store_writer #(
    .ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW), .MAX_DIM(5), .ALLOC_WAIT(AWAIT), .TIMEOUT_CYCLES(TOC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .req_m(req_m), .req_n(req_n), .abort(abort),
    .busy(busy), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .alloc_req(alloc_req), .alloc_m(alloc_m), .alloc_n(alloc_n), .alloc_slot(alloc_slot),
    .alloc_addr(alloc_addr), .alloc_valid(alloc_valid), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_din(bram_din), .commit_req(commit_req),
    .commit_slot(commit_slot), .commit_m(commit_m), .commit_n(commit_n),
    .commit_addr(commit_addr), .done(done), .result_slot(result_slot), .err(err),
    .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: counters only grow, stimulus takes snapshots and compares deltas.
  typedef struct packed { logic [AW-1:0] addr; logic [EW-1:0] data; } wr_t;
  wr_t        wr_log[$];
  int         n_alloc = 0, n_commit = 0, n_done = 0, n_err = 0;
  int         commit_cyc = 0, done_cyc = 0, err_cyc = 0, last_wr_cyc = 0;
  logic [3:0] c_slot;
  logic [4:0] c_m, c_n;
  logic [AW-1:0] c_addr;
  logic [1:0] e_code;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bram_we) begin
        wr_log.push_back('{addr: bram_addr, data: bram_din});
        last_wr_cyc = cyc;
      end
      if (alloc_req) n_alloc++;
      if (commit_req) begin
        n_commit++; commit_cyc = cyc;
        c_slot = commit_slot; c_m = commit_m; c_n = commit_n; c_addr = commit_addr;
      end
      if (done) begin n_done++; done_cyc = cyc; end
      if (err) begin n_err++; err_cyc = cyc; e_code = err_code; end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One store transaction: model predicts the write list and outcome from the rules alone.
  task automatic do_store(input string tag, input int m, input int n, input int gdelay,
                          input logic [3:0] slot, input logic [AW-1:0] base, input int gap,
                          input int abort_at, input bit hold_start);
    int total, sent, guard, w0, a0, d0, e0, c0, t0;
    bit v, ab;
    logic [EW-1:0] dv;
    logic [EW-1:0] exp_data[$];
    logic [AW-1:0] ea;
    total = m * n;
    w0 = wr_log.size(); a0 = n_alloc; d0 = n_done; e0 = n_err; c0 = n_commit;
    req_m = 5'(m); req_n = 5'(n); start = 1'b1; t0 = cyc;
    tick();
    if (!hold_start) start = 1'b0;
    tick();
    repeat (gdelay) tick();
    alloc_valid = 1'b1; alloc_slot = slot; alloc_addr = base;
    tick();
    alloc_valid = 1'b0; alloc_slot = 4'($urandom); alloc_addr = AW'($urandom);
    sent = 0; guard = 0; ab = 1'b0;
    while (sent < total && !ab && guard < 400) begin
      case (gap)
        0:       v = 1'b1;
        1:       v = (guard % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      dv = EW'($urandom);
      in_valid = v; in_data = dv;
      if (v && sent == abort_at) begin abort = 1'b1; ab = 1'b1; end
      tick();
      if (v && !ab) begin exp_data.push_back(dv); sent++; end
      guard++;
    end
    in_valid = 1'b0; abort = 1'b0; start = 1'b0;
    guard = 0;
    while (n_done == d0 && n_err == e0 && guard < 20) begin tick(); guard++; end
    check({tag, "_outcome_in_time"}, 32'(guard < 20), 1);
    tick(); tick();
    check({tag, "_alloc_count"}, n_alloc - a0, 1);
    check({tag, "_write_count"}, wr_log.size() - w0, exp_data.size());
    for (int i = 0; i < exp_data.size() && (w0 + i) < wr_log.size(); i++) begin
      ea = base + AW'(i);
      check({tag, "_wr_addr"}, wr_log[w0 + i].addr, ea);
      check({tag, "_wr_data"}, wr_log[w0 + i].data, exp_data[i]);
    end
    check({tag, "_busy_end"}, busy, 0);
    if (ab) begin
      check({tag, "_err_count"}, n_err - e0, 1);
      check({tag, "_err_code"}, e_code, 2);
      check({tag, "_no_commit"}, n_commit - c0, 0);
      check({tag, "_no_done"}, n_done - d0, 0);
    end else begin
      check({tag, "_no_err"}, n_err - e0, 0);
      check({tag, "_commit_count"}, n_commit - c0, 1);
      check({tag, "_commit_slot"}, c_slot, slot);
      check({tag, "_commit_m"}, c_m, m);
      check({tag, "_commit_n"}, c_n, n);
      check({tag, "_commit_addr"}, c_addr, base);
      check({tag, "_done_count"}, n_done - d0, 1);
      check({tag, "_result_slot"}, result_slot, slot);
      check({tag, "_commit_with_last_write"}, commit_cyc, last_wr_cyc);
      check({tag, "_done_after_commit"}, done_cyc, commit_cyc + 1);
      if (gap == 0) check({tag, "_full_rate_latency"}, done_cyc - t0, total + 4 + gdelay);
    end
  endtask

  int a0, w0, e0, c0, t0, d0, guard;

  initial begin
    start = 0; req_m = 0; req_n = 0; abort = 0; in_valid = 0; in_data = 0;
    alloc_slot = 0; alloc_addr = 0; alloc_valid = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_alloc_req", alloc_req, 0);
    check("rst_bram_we", bram_we, 0);
    check("rst_commit_req", commit_req, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_bram_addr", bram_addr, 0);
    check("rst_bram_din", bram_din, 0);
    check("rst_result_slot", result_slot, 4'hF);
    check("rst_commit_addr", commit_addr, 0);
    check("rst_alloc_m", alloc_m, 0);
    rst_n = 1'b1;
    tick();

    // 2x3 store, slot 4 at 0x010, cycle-exact
    req_m = 2; req_n = 3; start = 1'b1;
    check("d_idle_busy", busy, 0);
    tick(); start = 1'b0;
    check("d_alloc_req", alloc_req, 1);
    check("d_busy", busy, 1);
    check("d_alloc_m", alloc_m, 2);
    check("d_alloc_n", alloc_n, 3);
    check("d_ready_alloc", in_ready, 0);
    tick();
    check("d_alloc_req_pulse", alloc_req, 0);
    alloc_valid = 1'b1; alloc_slot = 4'd4; alloc_addr = 12'h010;
    tick(); alloc_valid = 1'b0;
    check("d_in_ready", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = EW'(i + 1);
      tick();
      check("d_wr_we", bram_we, 1);
      check("d_wr_addr", bram_addr, 32'h010 + i);
      check("d_wr_din", bram_din, i + 1);
      if (i < 5) check("d_commit_early", commit_req, 0);
    end
    in_valid = 1'b0;
    check("d_commit_req", commit_req, 1);
    check("d_commit_slot", commit_slot, 4);
    check("d_commit_m", commit_m, 2);
    check("d_commit_n", commit_n, 3);
    check("d_commit_addr", commit_addr, 12'h010);
    check("d_done_early", done, 0);
    tick();
    check("d_done", done, 1);
    check("d_result_slot", result_slot, 4);
    check("d_busy_done", busy, 0);
    check("d_commit_pulse", commit_req, 0);
    check("d_we_after", bram_we, 0);
    tick();
    check("d_done_pulse", done, 0);
    check("d_result_hold", result_slot, 4);

    // Illegal dimensions
    a0 = n_alloc;
    req_m = 0; req_n = 3; start = 1'b1;
    tick(); start = 1'b0;
    check("dim0_err", err, 1);
    check("dim0_code", err_code, 0);
    check("dim0_busy", busy, 0);
    tick();
    check("dim0_err_pulse", err, 0);
    req_m = 3; req_n = 6; start = 1'b1;
    tick(); start = 1'b0;
    check("dim6_err", err, 1);
    check("dim6_code", err_code, 0);
    check("dim6_busy", busy, 0);
    tick(); tick();
    check("dim_no_alloc", n_alloc - a0, 0);

    // Grant withheld
    w0 = wr_log.size(); e0 = n_err; c0 = n_commit;
    req_m = 2; req_n = 2; start = 1'b1; t0 = cyc;
    tick(); start = 1'b0;
    guard = 0;
    while (n_err == e0 && guard < 12) begin tick(); guard++; end
    check("nospace_in_time", 32'(guard < 12), 1);
    check("nospace_code", e_code, 1);
    check("nospace_latency", err_cyc - t0, 2 + AWAIT);
    check("nospace_busy", busy, 0);
    check("nospace_no_write", wr_log.size() - w0, 0);
    check("nospace_no_commit", n_commit - c0, 0);
    tick();

    do_store("abort3x3", 3, 3, 0, 4'd7, 12'h100, 1, 4, 1'b0);
    do_store("abort1x1", 1, 1, 0, 4'd2, 12'h020, 0, 0, 1'b1);
    do_store("max5x5", 5, 5, 0, 4'd9, 12'hFF0, 0, -1, 1'b0);
    for (int r = 0; r < 8; r++) begin
      do_store("rand", $urandom_range(1, 5), $urandom_range(1, 5), $urandom_range(0, 1),
               4'($urandom), AW'($urandom), $urandom_range(0, 2), -1, 1'b0);
    end

    // Reset in the middle of a stream never commits
    c0 = n_commit;
    req_m = 2; req_n = 2; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    alloc_valid = 1'b1; alloc_slot = 4'd3; alloc_addr = 12'h040;
    tick(); alloc_valid = 1'b0;
    in_valid = 1'b1; in_data = 8'h55;
    tick(); in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_ready", in_ready, 0);
    check("midrst_result_slot", result_slot, 4'hF);
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1;
    repeat (4) tick();
    in_valid = 1'b0;
    check("midrst_no_commit", n_commit - c0, 0);
    check("midrst_idle", busy, 0);

`ifdef STORE_WRITE_TIMEOUT_EN
    e0 = n_err; c0 = n_commit;
    req_m = 2; req_n = 2; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    alloc_valid = 1'b1; alloc_slot = 4'd5; alloc_addr = 12'h080;
    tick(); alloc_valid = 1'b0;
    in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    guard = 0;
    while (n_err == e0 && guard < 40) begin tick(); guard++; end
    check("to_in_time", 32'(guard < 40), 1);
    check("to_code", e_code, 3);
    check("to_idle_cycles", err_cyc - last_wr_cyc, TOC);
    check("to_no_commit", n_commit - c0, 0);
    check("to_busy", busy, 0);
`else
    e0 = n_err; d0 = n_done;
    req_m = 2; req_n = 1; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    alloc_valid = 1'b1; alloc_slot = 4'd6; alloc_addr = 12'h0A0;
    tick(); alloc_valid = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (40) tick();
    check("stall_still_busy", busy, 1);
    check("stall_no_err", n_err - e0, 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("stall_done", n_done - d0, 1);
    check("stall_result_slot", result_slot, 6);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule
